// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Programmable instruction sequencer for the TPU datapath. Holds a
//            writable instruction memory, then fetches and decodes one
//            instruction at a time. It drives the control strobes and the
//            base address used by the weight memory, input setup, MMU,
//            accumulators and unified buffer.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start, abort        - run control (abort has priority)
//            prog_we/addr/data   - instruction memory write port (idle only)
//            busy, done, error   - status (error is sticky until start/reset)
//            pc                  - current program counter
//            base_address        - operand of the last LOAD_ADDR
//            load_weight, load_input, store - one-cycle strobes
//            valid               - high for the whole compute window
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int INSTR_W        = 16,
    parameter int ADDR_W         = INSTR_W - 3,
    parameter int IMEM_DEPTH     = 8,
    parameter int PC_W           = $clog2(IMEM_DEPTH),
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [PC_W-1:0]    pc,
    output logic [ADDR_W-1:0]  base_address,
    output logic               load_weight,
    output logic               load_input,
    output logic               valid,
    output logic               store
);

    // ------------------------------------------------------------------
    // State and opcode encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_EXECUTE = 3'd2;
    localparam logic [2:0] c_ST_COMPUTE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    localparam logic [2:0] c_OP_HALT        = 3'b000;
    localparam logic [2:0] c_OP_LOAD_ADDR   = 3'b001;
    localparam logic [2:0] c_OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] c_OP_LOAD_INPUT  = 3'b011;
    localparam logic [2:0] c_OP_COMPUTE     = 3'b100;
    localparam logic [2:0] c_OP_STORE       = 3'b101;
    localparam logic [2:0] c_OP_NOP         = 3'b110;
    localparam logic [2:0] c_OP_ILLEGAL     = 3'b111;

    localparam logic [PC_W-1:0]   c_LAST_PC     = PC_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_DEFAULT_CNT = ADDR_W'(COMPUTE_CYCLES);

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_error;

    logic [2:0]         w_opcode;
    logic [ADDR_W-1:0]  w_operand;
    logic [ADDR_W-1:0]  w_cnt_load;
    logic               w_last_pc;
    logic               w_cnt_last;
    logic               w_launch;
    logic               w_step;
    logic               w_busy;

    assign w_opcode   = r_instr[INSTR_W-1 -: 3];
    assign w_operand  = r_instr[ADDR_W-1:0];
    // An operand of zero selects the default compute length.
    assign w_cnt_load = (w_operand == '0) ? c_DEFAULT_CNT : w_operand;
    assign w_last_pc  = (r_pc == c_LAST_PC);
    assign w_cnt_last = (r_cnt == ADDR_W'(1));
    assign w_busy     = (r_state == c_ST_FETCH) || (r_state == c_ST_EXECUTE) ||
                        (r_state == c_ST_COMPUTE);

    // A run is launched only from IDLE/DONE; abort overrides start.
    assign w_launch = start && !abort &&
                      ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // Completion of a non-terminating instruction: a plain instruction in
    // EXECUTE, or the last cycle of a compute window.
    always_comb begin
        w_step = 1'b0;
        if (r_state == c_ST_EXECUTE) begin
            w_step = (w_opcode != c_OP_HALT) && (w_opcode != c_OP_ILLEGAL) &&
                     (w_opcode != c_OP_COMPUTE);
        end else if (r_state == c_ST_COMPUTE) begin
            w_step = w_cnt_last;
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory: not reset, so the program survives reset. Writes
    // are blocked while a program is running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (prog_we && !w_busy) begin
            r_imem[prog_addr] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_state_next = c_ST_EXECUTE;
            end
            c_ST_EXECUTE: begin
                case (w_opcode)
                    c_OP_HALT,
                    c_OP_ILLEGAL: w_state_next = c_ST_DONE;
                    c_OP_COMPUTE: w_state_next = c_ST_COMPUTE;
                    // Running off the end of memory is an implicit halt.
                    default:      w_state_next = w_last_pc ? c_ST_DONE : c_ST_FETCH;
                endcase
            end
            c_ST_COMPUTE: begin
                if (w_cnt_last) begin
                    w_state_next = w_last_pc ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_DONE: begin
                if (start) begin
                    w_state_next = c_ST_FETCH;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, decoded from state and instruction register
    // only, so strobes can never appear outside EXECUTE/COMPUTE and at most
    // one is high in any cycle.
    // ------------------------------------------------------------------
    always_comb begin
        busy        = w_busy;
        done        = (r_state == c_ST_DONE);
        load_weight = 1'b0;
        load_input  = 1'b0;
        store       = 1'b0;
        valid       = (r_state == c_ST_COMPUTE);
        if (r_state == c_ST_EXECUTE) begin
            load_weight = (w_opcode == c_OP_LOAD_WEIGHT);
            load_input  = (w_opcode == c_OP_LOAD_INPUT);
            store       = (w_opcode == c_OP_STORE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: program counter, instruction register, base address,
    // compute counter and sticky error flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_base  <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else if (abort) begin
            // Abort keeps base address and error; only the window is killed.
            r_cnt <= '0;
        end else begin
            if (w_launch) begin
                r_pc    <= '0;
                r_error <= 1'b0;
            end else if (w_step && !w_last_pc) begin
                r_pc <= r_pc + PC_W'(1);
            end

            if (r_state == c_ST_FETCH) begin
                r_instr <= r_imem[r_pc];
            end

            if (r_state == c_ST_EXECUTE) begin
                case (w_opcode)
                    c_OP_LOAD_ADDR: r_base  <= w_operand;
                    c_OP_COMPUTE:   r_cnt   <= w_cnt_load;
                    c_OP_ILLEGAL:   r_error <= 1'b1;
                    c_OP_HALT, c_OP_LOAD_WEIGHT, c_OP_LOAD_INPUT,
                    c_OP_STORE, c_OP_NOP: ;
                    default: ;
                endcase
            end

            if (r_state == c_ST_COMPUTE) begin
                r_cnt <= r_cnt - ADDR_W'(1);
            end
        end
    end

    assign pc           = r_pc;
    assign base_address = r_base;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer. Directed steps push the
//            expected event stream (base address changes, strobes, valid
//            window lengths, gaps between windows, done latency) into a
//            scoreboard queue; a negedge monitor pops and compares each
//            event as the sequencer produces it. Status outputs are checked
//            directly at chosen points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 13;
    localparam int DEPTH   = 8;
    localparam int PC_W    = 3;

    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_LA   = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_LI   = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_BAD  = 3'b111;

    localparam logic [3:0] EV_BASE  = 4'd1;
    localparam logic [3:0] EV_LW    = 4'd2;
    localparam logic [3:0] EV_LI    = 4'd3;
    localparam logic [3:0] EV_VALID = 4'd4;
    localparam logic [3:0] EV_STORE = 4'd5;
    localparam logic [3:0] EV_DONE  = 4'd6;
    localparam logic [3:0] EV_GAP   = 4'd7;

    logic               clk = 1'b0;
    logic               reset, start, abort, prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               busy, done, error;
    logic [PC_W-1:0]    pc;
    logic [ADDR_W-1:0]  base_address;
    logic               load_weight, load_input, valid, store;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(DEPTH),
        .PC_W(PC_W), .COMPUTE_CYCLES(6)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .busy(busy), .done(done), .error(error), .pc(pc),
        .base_address(base_address), .load_weight(load_weight),
        .load_input(load_input), .valid(valid), .store(store)
    );

    function automatic logic [INSTR_W-1:0] ins(input logic [2:0] op, input int opnd);
        logic [31:0] v;
        v = opnd;
        return {op, v[ADDR_W-1:0]};
    endfunction

    function automatic logic [31:0] ev(input logic [3:0] kind, input int value);
        logic [31:0] v;
        v = value;
        return {kind, v[27:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
        end
    endtask

    task automatic sb_check(input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_unexpected observed=%h required=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL sb_event observed=%h required=%h", obs, e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor. "since" counts clock edges from the edge that sampled start,
    // so the done event carries the start-to-done latency in cycles.
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [ADDR_W-1:0] prev_base;
        logic              prev_done;
        int                vrun, lowrun, since, nstb;
        bit                had_win, armed;
        prev_base = '0; prev_done = 1'b0;
        vrun = 0; lowrun = 0; since = 0; had_win = 1'b0; armed = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (armed) since++;
                if (valid) begin
                    if (vrun == 0 && had_win) sb_check(ev(EV_GAP, lowrun));
                    vrun++;
                end else begin
                    if (vrun > 0) begin
                        sb_check(ev(EV_VALID, vrun));
                        vrun = 0; had_win = 1'b1; lowrun = 0;
                    end
                    lowrun++;
                end
                if (base_address !== prev_base) begin
                    sb_check(ev(EV_BASE, int'(base_address)));
                    prev_base = base_address;
                end
                if (load_weight) sb_check(ev(EV_LW, 0));
                if (load_input)  sb_check(ev(EV_LI, 0));
                if (store)       sb_check(ev(EV_STORE, 0));
                if (done && !prev_done) sb_check(ev(EV_DONE, since));
                prev_done = done;
                nstb = int'(load_weight) + int'(load_input) + int'(valid) + int'(store);
                check("strobe_exclusive", ((nstb <= 1) && (busy || nstb == 0)), 1'b1);
                if (start && !busy && !abort && !reset) begin
                    armed = 1'b1; since = -1; had_win = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input logic [INSTR_W-1:0] data);
        prog_we   = 1'b1;
        prog_addr = addr[PC_W-1:0];
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", done, 1'b1);
    endtask

    task automatic wait_valid(input int bound);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("valid_seen", valid, 1'b1);
    endtask

    task automatic load_p1();
        write_mem(0, ins(OP_LA, 'h00F));
        write_mem(1, ins(OP_LW, 0));
        write_mem(2, ins(OP_LA, 'h01E));
        write_mem(3, ins(OP_LI, 0));
        write_mem(4, ins(OP_CMP, 0));
        write_mem(5, ins(OP_LA, 'h007));
        write_mem(6, ins(OP_ST, 0));
        write_mem(7, ins(OP_HALT, 0));
    endtask

    task automatic push_p1_head();
        exp_q.push_back(ev(EV_BASE, 'h00F));
        exp_q.push_back(ev(EV_LW, 0));
        exp_q.push_back(ev(EV_BASE, 'h01E));
        exp_q.push_back(ev(EV_LI, 0));
    endtask

    task automatic push_p1_full();
        push_p1_head();
        exp_q.push_back(ev(EV_VALID, 6));
        exp_q.push_back(ev(EV_BASE, 'h007));
        exp_q.push_back(ev(EV_STORE, 0));
        exp_q.push_back(ev(EV_DONE, 22));
    endtask

    initial begin : stim
        reset = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0;

        // Reset state
        step(); step(); step();
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_pc", pc, 0);
        check("rst_base", base_address, 0);
        check("rst_strobes", {load_weight, load_input, valid, store}, 0);
        step();
        reset = 1'b0;
        mon_en = 1'b1;

        // Main program: loads, default compute length, store, halt
        load_p1();
        push_p1_full();
        pulse_start();
        wait_done(60);
        check("p1_pc", pc, 7);
        check("p1_error", error, 1'b0);
        check("p1_busy", busy, 1'b0);
        check("p1_queue", exp_q.size(), 0);

        // Back-to-back compute windows of 3 and 1
        step();
        write_mem(0, ins(OP_CMP, 3));
        write_mem(1, ins(OP_CMP, 1));
        write_mem(2, ins(OP_HALT, 0));
        exp_q.push_back(ev(EV_VALID, 3));
        exp_q.push_back(ev(EV_GAP, 2));
        exp_q.push_back(ev(EV_VALID, 1));
        exp_q.push_back(ev(EV_DONE, 10));
        pulse_start();
        wait_done(40);
        check("cmp_pc", pc, 2);
        check("cmp_queue", exp_q.size(), 0);

        // No HALT: implicit halt at the end of memory, run twice
        step();
        for (int i = 0; i < DEPTH; i++) write_mem(i, ins(OP_NOP, 0));
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(ev(EV_DONE, 16));
            pulse_start();
            wait_done(40);
            check("nop_pc", pc, 7);
            check("nop_error", error, 1'b0);
            step();
        end
        check("nop_queue", exp_q.size(), 0);

        // Illegal opcode at pc=2
        write_mem(2, ins(OP_BAD, 0));
        write_mem(3, ins(OP_HALT, 0));
        exp_q.push_back(ev(EV_DONE, 6));
        pulse_start();
        wait_done(30);
        check("ill_error", error, 1'b1);
        check("ill_pc", pc, 2);
        step();
        exp_q.push_back(ev(EV_DONE, 6));
        pulse_start();
        @(negedge clk);
        check("ill_error_cleared", error, 1'b0);
        wait_done(30);
        check("ill_error_again", error, 1'b1);

        // Write and start in the same cycle: fetch of pc=0 sees new HALT
        step();
        exp_q.push_back(ev(EV_DONE, 2));
        prog_we = 1'b1; prog_addr = '0; prog_data = ins(OP_HALT, 0);
        start = 1'b1;
        step();
        start = 1'b0; prog_we = 1'b0;
        wait_done(20);
        check("wr_start_pc", pc, 0);
        check("wr_start_error", error, 1'b0);
        check("wr_start_queue", exp_q.size(), 0);

        // Abort on the third valid cycle
        step();
        load_p1();
        push_p1_head();
        exp_q.push_back(ev(EV_VALID, 3));
        pulse_start();
        wait_valid(40);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_base", base_address, 'h01E);
        check("abort_queue", exp_q.size(), 0);

        // Write attempted while busy must be ignored (store stays in program)
        step();
        push_p1_full();
        pulse_start();
        write_mem(6, ins(OP_NOP, 0));
        write_mem(6, ins(OP_NOP, 0));
        wait_done(60);
        step();
        push_p1_full();
        pulse_start();
        wait_done(60);
        check("busy_wr_queue", exp_q.size(), 0);

        // Reset in the middle of a compute window
        step();
        push_p1_head();
        exp_q.push_back(ev(EV_VALID, 2));
        exp_q.push_back(ev(EV_BASE, 0));
        pulse_start();
        wait_valid(40);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("mrst_valid", valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_pc", pc, 0);
        check("mrst_base", base_address, 0);
        check("mrst_error", error, 1'b0);
        step();
        reset = 1'b0;
        step();
        push_p1_full();
        pulse_start();
        wait_done(60);
        check("mrst_rerun_pc", pc, 7);
        @(negedge clk);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
